// File: rtl/bit_matrix_transposer.sv
// rtl/bit_matrix_transposer.sv - double-buffered streaming bit-matrix transposer
module bit_matrix_transposer #(
  parameter int ROWS = 32,
  parameter int COLS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [ROWS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [1:0]      banks_full
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  // Two ping-pong banks, each ROWS rows of COLS bits
  logic [ROWS-1:0][COLS-1:0] bank_mem [2];

  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            wr_bank;
  logic            rd_bank;
  logic [RW-1:0]   wr_row;
  logic [CW-1:0]   rd_col;
  logic            wr_fire;
  logic            rd_fire;
  logic            wr_done;
  logic            rd_done;
  logic [ROWS-1:0] col_word;

  // Handshakes depend only on registered flags, so out_ready never reaches in_ready
  assign in_ready   = ~full[wr_bank];
  assign out_valid  = full[rd_bank];
  assign wr_fire    = in_valid & in_ready;
  assign rd_fire    = out_valid & out_ready;
  assign wr_done    = wr_fire & (wr_row == ROW_LAST);
  assign rd_done    = rd_fire & (rd_col == COL_LAST);
  assign out_data   = out_valid ? col_word : '0;
  assign out_last   = out_valid & (rd_col == COL_LAST);
  assign banks_full = full;

  // Row capture; bank contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      bank_mem[wr_bank][wr_row] <= in_data;
    end
  end

  // Gather bit rd_col of every stored row into one output column
  always_comb begin
    col_word = '0;
    for (int k = 0; k < ROWS; k++) begin
      col_word[k] = bank_mem[rd_bank][k][rd_col];
    end
  end

  // Fill on the last row written, drain on the last column read; the two
  // sides always address different banks so both updates can land together
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  // Write/read pointers and bank-full flags
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        if (wr_row == ROW_LAST) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + RW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_col == COL_LAST) begin
          rd_col  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_col <= rd_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_matrix_transposer.sv
// tb/tb_bit_matrix_transposer.sv - self-checking bench for bit_matrix_transposer
module tb_bit_matrix_transposer;

  localparam int SR = 4;
  localparam int SC = 8;
  localparam int BR = 32;
  localparam int BC = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [SC-1:0] s_in_data = '0;
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [SR-1:0] s_out_data;
  logic          s_out_valid;
  logic          s_out_ready = 1'b0;
  logic          s_out_last;
  logic [1:0]    s_banks_full;

  logic [BC-1:0] b_in_data = '0;
  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [BR-1:0] b_out_data;
  logic          b_out_valid;
  logic          b_out_ready = 1'b0;
  logic          b_out_last;
  logic [1:0]    b_banks_full;

  bit_matrix_transposer #(.ROWS(SR), .COLS(SC)) u_small (
    .clk(clk), .reset(reset),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last), .banks_full(s_banks_full)
  );

  bit_matrix_transposer u_big (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_last(b_out_last), .banks_full(b_banks_full)
  );

  int n_vec = 0;
  int n_err = 0;
  int beats = 0;

  logic [SC-1:0] tx[$];
  logic [SC-1:0] acc[$];
  logic [SR:0]   exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Reference: column j of a matrix is bit j of each row, row k landing at bit k
  task automatic model_matrix();
    logic [SR-1:0] col;
    for (int j = 0; j < SC; j++) begin
      col = '0;
      for (int k = 0; k < SR; k++) col[k] = acc[k][j];
      exp_q.push_back({(j == SC - 1), col});
    end
    acc.delete();
  endtask

  task automatic step(input logic iv, input logic ordy);
    logic [SR:0] e;
    @(negedge clk);
    s_in_valid  = iv && (tx.size() > 0);
    s_in_data   = (tx.size() > 0) ? tx[0] : SC'($urandom);
    s_out_ready = ordy;
    #1;
    if (s_out_valid && s_out_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        chk("extra_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("col_data", 64'(s_out_data), 64'(e[SR-1:0]));
        chk("col_last", 64'(s_out_last), 64'(e[SR]));
      end
    end
    if (s_in_valid && s_in_ready) begin
      acc.push_back(tx.pop_front());
      if (acc.size() == SR) model_matrix();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tx.delete(); acc.delete(); exp_q.delete();
    #1;
    chk("rst_in_ready", 64'(s_in_ready), 64'd1);
    chk("rst_out_valid", 64'(s_out_valid), 64'd0);
    chk("rst_out_last", 64'(s_out_last), 64'd0);
    chk("rst_out_data", 64'(s_out_data), 64'd0);
    chk("rst_banks_full", 64'(s_banks_full), 64'd0);
  endtask

  initial begin
    logic [SR-1:0] held_data;
    logic          held_last;
    logic [BR-1:0] bwant;
    int            cyc;
    int            j;

    // Reset and idle
    do_reset();
    chk("big_rst_in_ready", 64'(b_in_ready), 64'd1);
    chk("big_rst_out_valid", 64'(b_out_valid), 64'd0);
    chk("big_rst_out_data", 64'(b_out_data), 64'd0);
    chk("big_rst_banks_full", 64'(b_banks_full), 64'd0);

    // 4x8 single-bit diagonal
    tx.push_back(8'h01); tx.push_back(8'h02); tx.push_back(8'h04); tx.push_back(8'h08);
    beats = 0;
    for (int i = 0; i < SR; i++) begin
      step(1'b1, 1'b1);
      chk("diag_no_early_valid", 64'(s_out_valid), 64'd0);
    end
    step(1'b0, 1'b1);
    chk("diag_first_latency", 64'(s_out_valid), 64'd1);
    chk("diag_col0", 64'(s_out_data), 64'h1);
    for (int i = 0; i < SC - 1; i++) step(1'b0, 1'b1);
    chk("diag_beats", 64'(beats), 64'(SC));
    step(1'b0, 1'b1);
    chk("diag_idle_after", 64'(s_out_valid), 64'd0);

    // 32x64 default geometry, row k = 1 << k
    for (int k = 0; k < BR; k++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 64'h1 << k; b_out_ready = 1'b1;
      #1;
      if (k == 0 || k == BR - 1) chk("big_in_ready", 64'(b_in_ready), 64'd1);
    end
    j = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      if (b_out_valid) begin
        bwant = (j < 32) ? (32'h1 << j) : 32'h0;
        chk("big_col", 64'(b_out_data), 64'(bwant));
        chk("big_last", 64'(b_out_last), 64'(j == BC - 1));
        j++;
      end
    end
    chk("big_beats", 64'(j), 64'(BC));

    // Back-pressure: three matrices offered with the output blocked
    do_reset();
    for (int i = 0; i < 3 * SR; i++) tx.push_back(SC'($urandom));
    beats = 0;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    chk("bp_rows_left", 64'(tx.size()), 64'(SR));
    chk("bp_banks_full", 64'(s_banks_full), 64'h3);
    chk("bp_in_ready", 64'(s_in_ready), 64'd0);
    chk("bp_out_valid", 64'(s_out_valid), 64'd1);
    held_data = s_out_data;
    held_last = s_out_last;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("bp_data_stable", 64'(s_out_data), 64'(held_data));
      chk("bp_last_stable", 64'(s_out_last), 64'(held_last));
    end
    for (int i = 0; i < SC; i++) begin
      step(1'b1, 1'b1);
      chk("bp_in_ready_drain", 64'(s_in_ready), 64'd0);
    end
    step(1'b1, 1'b1);
    chk("bp_in_ready_return", 64'(s_in_ready), 64'd1);
    cyc = 0;
    while ((tx.size() > 0 || acc.size() > 0 || exp_q.size() > 0) && cyc < 200) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    chk("bp_drained", 64'(exp_q.size() + tx.size()), 64'd0);
    chk("bp_beats", 64'(beats), 64'(3 * SC));

    // Random valid/ready over 100 matrices
    do_reset();
    for (int i = 0; i < 100 * SR; i++) tx.push_back(SC'($urandom));
    beats = 0;
    cyc = 0;
    while ((tx.size() > 0 || acc.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_timeout", 64'(cyc < 20000), 64'd1);
    chk("rand_beats", 64'(beats), 64'(100 * SC));
    chk("rand_pending", 64'(exp_q.size()), 64'd0);

    // Reset after two rows loaded
    for (int i = 0; i < 2; i++) tx.push_back(SC'($urandom));
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    do_reset();

    // Reset mid-drain
    for (int i = 0; i < SR; i++) tx.push_back(SC'($urandom));
    for (int i = 0; i < SR; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    do_reset();
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      chk("post_rst_no_stale", 64'(s_out_valid), 64'd0);
    end

    // Fresh matrix after the resets
    for (int i = 0; i < SR; i++) tx.push_back(SC'($urandom));
    cyc = 0;
    while ((tx.size() > 0 || acc.size() > 0 || exp_q.size() > 0) && cyc < 100) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    chk("post_rst_beats", 64'(beats), 64'(SC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
